// File: rtl/ram_arbiter_rr_if.sv
//------------------------------------------------------------------------------
// ram_arbiter_rr_if : requester, response and RAM-side bundle for ram_arbiter_rr
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_arbiter_rr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              init_done;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output init_done
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  init_done
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter_rr.sv
//------------------------------------------------------------------------------
// ram_arbiter_rr : two-port round-robin arbiter in front of a single-port RAM
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter_rr #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int INIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_rr_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t c_RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic   c_DONE_RST  = (INIT_EN != 0) ? 1'b0 : 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_last_gnt;
  logic              r_init_done;
  logic              r_s1_valid;
  logic              r_s1_tag;
  logic              r_s2_valid;
  logic              r_s2_tag;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_fill_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_fill_last = (r_cnt == {ADDR_W{1'b1}});
    case (r_state)
      ST_INIT: begin
        if (w_fill_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // On contention the port that did not win last time goes first
        w_gnt0 = bus.req0_valid && (!bus.req1_valid ||  r_last_gnt);
        w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_gnt);
      end
      default: w_state_nxt = c_RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_last_gnt  <= 1'b1;
      r_init_done <= c_DONE_RST;
      r_s1_valid  <= 1'b0;
      r_s1_tag    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_tag    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      r_s1_valid <= 1'b0;
      r_ram_en   <= 1'b0;
      if (r_state == ST_INIT) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= r_cnt;
        r_ram_wdata <= '0;
        r_cnt       <= r_cnt + 1'b1;
        if (w_fill_last) begin
          r_init_done <= 1'b1;
        end
      end else if (w_gnt0 || w_gnt1) begin
        r_ram_en    <= 1'b1;
        r_s1_valid  <= 1'b1;
        r_s1_tag    <= w_gnt1;
        r_last_gnt  <= w_gnt1;
        r_ram_we    <= w_gnt1 ? bus.req1_we    : bus.req0_we;
        r_ram_addr  <= w_gnt1 ? bus.req1_addr  : bus.req0_addr;
        r_ram_wdata <= w_gnt1 ? bus.req1_wdata : bus.req0_wdata;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.ram_en     = r_ram_en;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.init_done  = r_init_done;

  // The RAM q lines up with stage 2; a write-first RAM returns the written word
  assign bus.rsp0_valid = r_s2_valid && !r_s2_tag;
  assign bus.rsp1_valid = r_s2_valid &&  r_s2_tag;
  assign bus.rsp0_rdata = (r_s2_valid && !r_s2_tag) ? bus.ram_rdata : '0;
  assign bus.rsp1_rdata = (r_s2_valid &&  r_s2_tag) ? bus.ram_rdata : '0;

endmodule

`default_nettype wire

// File: doc/ram_arbiter_rr.md
RAM_ARBITER_RR -- requirements
Module: ram_arbiter_rr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, RAM word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, RAM address width in bits (depth 2^ADDR_W).
REQ-003 The block SHALL have parameter INIT_EN, default 1; 1 = zero-fill the RAM after reset, 0 = skip fill.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, named as the codebase does:
- clk  in  1  rising-edge clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these requester ports, for each port i in {0,1}:
- reqi_valid  in  1  request present.
- reqi_ready  out  1  request accepted this cycle.
- reqi_we  in  1  1 = write, 0 = read.
- reqi_addr  in  ADDR_W  word address.
- reqi_wdata  in  DATA_W  write data.
- rspi_valid  out  1  response strobe.
- rspi_rdata  out  DATA_W  response data.
REQ-006 The block SHALL have these RAM-side ports, driving a single-port synchronous RAM with registered output and write-first behaviour:
- ram_en  out  1  access strobe.
- ram_we  out  1  write enable.
- ram_addr  out  ADDR_W  address.
- ram_wdata  out  DATA_W  write data.
- ram_rdata  in  DATA_W  RAM q; valid one cycle after ram_en.
REQ-007 The block SHALL have output init_done, 1 bit; high once the fill completes (or immediately after reset if INIT_EN=0).

Function
REQ-008 The FSM SHALL have exactly two states, INIT and RUN. Reset enters INIT if INIT_EN=1, otherwise RUN.
REQ-009 In INIT, an ADDR_W-bit counter starting at 0 SHALL issue one write per cycle: ram_en=1, ram_we=1, ram_addr=counter, ram_wdata=0.
REQ-010 When the INIT counter reaches 2^ADDR_W-1, that write SHALL be issued, the FSM SHALL move to RUN on the next edge, and init_done SHALL rise in the same cycle RUN is entered.
REQ-011 In INIT, req0_ready and req1_ready SHALL be 0, and rsp0_valid and rsp1_valid SHALL be 0.
REQ-012 In RUN, at most one request SHALL be granted per cycle. reqi_ready is combinational and is 1 only for the granted port.
REQ-013 Arbitration SHALL be round-robin, with pointer last_gnt updated only on a grant:
- If only one port is valid, that port is granted.
- If both are valid, the port other than last_gnt is granted.
REQ-014 last_gnt SHALL reset to 1, so port 0 wins the first two-way contention.
REQ-015 A request accepted on edge N (valid && ready) SHALL be registered into stage 1. The block SHALL drive ram_en=1 with the registered we/addr/wdata during cycle N+1.
REQ-016 Stage 1 SHALL forward a port tag and we bit into stage 2. In cycle N+2, rspi_valid SHALL be 1 for exactly one cycle on the tagged port only, with rspi_rdata = ram_rdata. Fixed latency is 2 cycles from accept to response, for both reads and writes.
REQ-017 For a write, the response data SHALL be the written data, which the write-first RAM returns.
REQ-018 rspi_rdata SHALL read as 0 whenever rspi_valid=0.
REQ-019 Sustained throughput SHALL be one access per cycle. There is no response backpressure.
REQ-020 Back-to-back write then read to the same address on consecutive cycles SHALL return the new data; the RAM's ordering guarantees this, and no forwarding logic is needed.
REQ-021 When no grant occurs in RUN, ram_en SHALL be 0 in the following cycle.
REQ-022 ram_we, ram_addr and ram_wdata SHALL be held at their last values when ram_en=0 and SHALL not be relied on.

Reset
REQ-023 rst_n low SHALL asynchronously clear all of the following:
- FSM to INIT (or RUN if INIT_EN=0).
- INIT counter = 0.
- last_gnt = 1.
- Both pipeline stage valids = 0.
- ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- rsp0_valid = 0, rsp1_valid = 0, rsp0_rdata = 0, rsp1_rdata = 0.
- init_done = 0 (1 if INIT_EN=0).
REQ-024 Reset asserted mid-INIT or mid-transaction SHALL discard all in-flight accesses with no response. After release, the INIT fill SHALL restart from address 0.
REQ-025 The first grant after reset release SHALL occur no earlier than the cycle in which init_done is first observed high.

Verification
REQ-026 Init fill (ADDR_W=4, INIT_EN=1): release reset -> exactly 16 consecutive ram writes to addr 0..15 with data 0, init_done high at cycle 16, readies 0 throughout the fill.
REQ-027 Single read: port 0 reads addr 0x0005 after a port 1 write of 0xA5 to addr 0x0005 -> rsp1_valid 2 cycles after the write with 0xA5, then rsp0_valid 2 cycles after the read with 0xA5, rsp1_valid low at that time.
REQ-028 Contention: both ports valid for 6 cycles with distinct addresses -> grants alternate 0,1,0,1,0,1 and each port receives 3 responses in order.
REQ-029 Streaming: port 0 valid for 8 consecutive cycles, port 1 idle -> 8 accepts on 8 consecutive edges, ram_en high for 8 cycles, and 8 responses on 8 consecutive cycles.
REQ-030 Reset mid-operation: assert rst_n low for 1 cycle while a read is in stage 1 -> no rsp0_valid/rsp1_valid for that read, init_done drops to 0, and the fill restarts at address 0.
REQ-031 INIT_EN=0: after reset release, init_done=1 and req0 is granted in the first cycle; the read response returns the RAM's uninitialised contents with rsp0_valid asserted 2 cycles after accept.
